// File: rtl/ps2_key_ctrl_if.sv
// Bundle of the FIFO-side handshake and the decoded key outputs of ps2_key_ctrl.
// slave: the controller (consumes FIFO, drives key state); master: the surrounding system.
// Pure wiring; no timing of its own.
interface ps2_key_ctrl_if;
    logic       kbd_ready;
    logic [7:0] kbd_data;
    logic       kbd_overflow;
    logic       kbd_nextdata_n;
    logic       clr_ovf;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic [7:0] press_count;
    logic       press_pulse;
    logic       ovf_sticky;

    modport slave (
        input  kbd_ready,
        input  kbd_data,
        input  kbd_overflow,
        input  clr_ovf,
        output kbd_nextdata_n,
        output key_valid,
        output key_code,
        output key_ext,
        output press_count,
        output press_pulse,
        output ovf_sticky
    );

    modport master (
        output kbd_ready,
        output kbd_data,
        output kbd_overflow,
        output clr_ovf,
        input  kbd_nextdata_n,
        input  key_valid,
        input  key_code,
        input  key_ext,
        input  press_count,
        input  press_pulse,
        input  ovf_sticky
    );
endinterface

// File: rtl/ps2_key_ctrl.sv
// Drains the PS/2 byte FIFO and decodes make/break/E0 codes into one held key plus a press counter.
// Latency: byte seen at edge E0 pops during E0->E1; key outputs and press_pulse update at E1.
// Backpressure: at most one pop per 3 cycles; kbd_ready is only looked at in IDLE.
module ps2_key_ctrl (
    input  logic           clk,
    input  logic           rst,
    ps2_key_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_ERR0 = 8'h00;
    localparam logic [7:0] CODE_ERR1 = 8'hFF;

    state_t     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       nextdata_n_q, nextdata_n_d;
    logic       key_valid_q, key_valid_d;
    logic [7:0] key_code_q, key_code_d;
    logic       key_ext_q, key_ext_d;
    logic [7:0] press_count_q, press_count_d;
    logic       press_pulse_q, press_pulse_d;
    logic       ovf_q, ovf_d;
    logic       ext_pend_q, ext_pend_d;
    logic       brk_pend_q, brk_pend_d;

    // The byte matches the currently held key (same code, same E0 prefix state).
    logic same_key;
    assign same_key = key_valid_q && (key_code_q == byte_q) && (key_ext_q == ext_pend_q);

    // Next-state: fetch sequencing, prefix tracking, held-key decode and sticky overflow.
    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        nextdata_n_d  = 1'b1;
        key_valid_d   = key_valid_q;
        key_code_d    = key_code_q;
        key_ext_d     = key_ext_q;
        press_count_d = press_count_q;
        press_pulse_d = 1'b0;
        ext_pend_d    = ext_pend_q;
        brk_pend_d    = brk_pend_q;

        case (state_q)
            S_IDLE: begin
                if (bus.kbd_ready) begin
                    byte_d       = bus.kbd_data;
                    nextdata_n_d = 1'b0;
                    state_d      = S_POP;
                end
            end
            S_POP: begin
                state_d = S_WAIT;
                if (byte_q == CODE_EXT) begin
                    ext_pend_d = 1'b1;
                end else if (byte_q == CODE_BRK) begin
                    brk_pend_d = 1'b1;
                end else if (byte_q == CODE_ERR0 || byte_q == CODE_ERR1) begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end else if (brk_pend_q) begin
                    // Release only clears the key if it names the key actually held.
                    if (same_key) begin
                        key_valid_d = 1'b0;
                        key_code_d  = 8'h00;
                        key_ext_d   = 1'b0;
                    end
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end else begin
                    // A make of the held key is typematic repeat and changes nothing.
                    if (!same_key) begin
                        key_valid_d   = 1'b1;
                        key_code_d    = byte_q;
                        key_ext_d     = ext_pend_q;
                        press_count_d = press_count_q + 8'd1;
                        press_pulse_d = 1'b1;
                    end
                    ext_pend_d = 1'b0;
                end
            end
            S_WAIT: begin
                // Dead cycle so the FIFO can present its next head before we look again.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new overflow in the same cycle as a clear keeps the flag set.
        if (bus.kbd_overflow) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State and registered outputs; reset overrides everything, dropping any byte already popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            byte_q        <= 8'h00;
            nextdata_n_q  <= 1'b1;
            key_valid_q   <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            press_count_q <= 8'h00;
            press_pulse_q <= 1'b0;
            ovf_q         <= 1'b0;
            ext_pend_q    <= 1'b0;
            brk_pend_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_q        <= byte_d;
            nextdata_n_q  <= nextdata_n_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            key_ext_q     <= key_ext_d;
            press_count_q <= press_count_d;
            press_pulse_q <= press_pulse_d;
            ovf_q         <= ovf_d;
            ext_pend_q    <= ext_pend_d;
            brk_pend_q    <= brk_pend_d;
        end
    end

    assign bus.kbd_nextdata_n = nextdata_n_q;
    assign bus.key_valid      = key_valid_q;
    assign bus.key_code       = key_code_q;
    assign bus.key_ext        = key_ext_q;
    assign bus.press_count    = press_count_q;
    assign bus.press_pulse    = press_pulse_q;
    assign bus.ovf_sticky     = ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: queue-backed FIFO model, held-key reference model, directed and random scenarios.
// The reference model is advanced on every pop and compared against the DUT every cycle.
// Scenario tasks additionally check end states against hand-derived constants.
module tb_ps2_key_ctrl;

    logic clk = 1'b0;
    logic rst;

    ps2_key_ctrl_if bus ();

    ps2_key_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q[$];
    int pulses_seen = 0;
    int lows_seen   = 0;
    bit mon_en      = 1'b0;

    // Reference model of the held key, described as "what key is down right now".
    bit         m_valid;
    logic [7:0] m_code;
    bit         m_ext;
    logic [7:0] m_count;
    bit         m_pulse;
    bit         m_ovf;
    bit         m_saw_e0;
    bit         m_saw_f0;

    task automatic model_reset();
        m_valid = 0; m_code = 8'h00; m_ext = 0; m_count = 8'h00;
        m_pulse = 0; m_ovf = 0; m_saw_e0 = 0; m_saw_f0 = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit held_same;
        if (b == 8'hE0) begin
            m_saw_e0 = 1;
        end else if (b == 8'hF0) begin
            m_saw_f0 = 1;
        end else if (b == 8'h00 || b == 8'hFF) begin
            m_saw_e0 = 0;
            m_saw_f0 = 0;
        end else begin
            held_same = m_valid && (m_code == b) && (m_ext == m_saw_e0);
            if (m_saw_f0) begin
                if (held_same) begin
                    m_valid = 0; m_code = 8'h00; m_ext = 0;
                end
            end else if (!held_same) begin
                m_valid = 1; m_code = b; m_ext = m_saw_e0;
                m_count = 8'((int'(m_count) + 1) % 256);
                m_pulse = 1;
            end
            m_saw_e0 = 0;
            m_saw_f0 = 0;
        end
    endtask

    // FIFO model: pops when the pop strobe was low across the preceding edge.
    initial begin
        bit nd_low_s;
        bus.kbd_ready = 1'b0;
        bus.kbd_data  = 8'h00;
        forever begin
            @(negedge clk);
            nd_low_s = (bus.kbd_nextdata_n === 1'b0);
            @(posedge clk);
            #1;
            if (nd_low_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
            bus.kbd_ready = (fifo_q.size() != 0);
            bus.kbd_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        end
    end

    // Cycle monitor: compare DUT to model, then advance model to what the next edge should produce.
    initial begin
        int cyc = 0;
        int last_low = -100;
        model_reset();
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cyc++;
                checks++;
                if (bus.key_valid !== m_valid || bus.key_code !== m_code || bus.key_ext !== m_ext ||
                    bus.press_count !== m_count || bus.press_pulse !== m_pulse) begin
                    errors++;
                    $display("FAIL cycle_key_state t=%0t got v=%0b c=%02h e=%0b n=%02h p=%0b expected v=%0b c=%02h e=%0b n=%02h p=%0b",
                             $time, bus.key_valid, bus.key_code, bus.key_ext, bus.press_count, bus.press_pulse,
                             m_valid, m_code, m_ext, m_count, m_pulse);
                end
                checks++;
                if (bus.ovf_sticky !== m_ovf) begin
                    errors++;
                    $display("FAIL cycle_ovf t=%0t got %0b expected %0b", $time, bus.ovf_sticky, m_ovf);
                end
                if (bus.press_pulse === 1'b1) pulses_seen++;
                if (bus.kbd_nextdata_n !== 1'b1) begin
                    checks++;
                    if (bus.kbd_nextdata_n !== 1'b0 || cyc - last_low < 3) begin
                        errors++;
                        $display("FAIL pop_spacing t=%0t nextdata_n=%0b gap=%0d expected gap>=3",
                                 $time, bus.kbd_nextdata_n, cyc - last_low);
                    end
                    last_low = cyc;
                    lows_seen++;
                end
                if (rst) begin
                    model_reset();
                end else begin
                    m_pulse = 0;
                    if (bus.kbd_nextdata_n === 1'b0 && fifo_q.size() > 0) model_byte(fifo_q[0]);
                    if (bus.kbd_overflow) m_ovf = 1;
                    else if (bus.clr_ovf) m_ovf = 0;
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((fifo_q.size() != 0 || bus.kbd_ready) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL drain_%s timeout left=%0d bytes expected 0", tag, fifo_q.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        push(8'h1C);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.kbd_ready !== 1'b1 || bus.kbd_nextdata_n !== 1'b1 || bus.key_valid !== 1'b0 ||
                bus.key_code !== 8'h00 || bus.key_ext !== 1'b0 || bus.press_count !== 8'h00 ||
                bus.press_pulse !== 1'b0 || bus.ovf_sticky !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold rdy=%0b nd=%0b v=%0b c=%02h e=%0b n=%02h p=%0b o=%0b expected rdy=1 nd=1 others 0",
                         bus.kbd_ready, bus.kbd_nextdata_n, bus.key_valid, bus.key_code, bus.key_ext,
                         bus.press_count, bus.press_pulse, bus.ovf_sticky);
            end
        end
        fifo_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_press();
        int l0, p0;
        do_reset();
        l0 = lows_seen; p0 = pulses_seen;
        push(8'h1C);
        drain("single_make");
        checks++;
        if (bus.key_valid !== 1'b1 || bus.key_code !== 8'h1C || bus.key_ext !== 1'b0 || bus.press_count !== 8'd1) begin
            errors++;
            $display("FAIL single_held got v=%0b c=%02h e=%0b n=%0d expected 1 1c 0 1",
                     bus.key_valid, bus.key_code, bus.key_ext, bus.press_count);
        end
        push(8'hF0); push(8'h1C);
        drain("single_break");
        checks++;
        if (bus.key_valid !== 1'b0 || bus.key_code !== 8'h00 || bus.press_count !== 8'd1) begin
            errors++;
            $display("FAIL single_released got v=%0b c=%02h n=%0d expected 0 00 1",
                     bus.key_valid, bus.key_code, bus.press_count);
        end
        checks++;
        if (lows_seen - l0 != 3 || pulses_seen - p0 != 1) begin
            errors++;
            $display("FAIL single_counts got pops=%0d pulses=%0d expected 3 1", lows_seen - l0, pulses_seen - p0);
        end
    endtask

    task automatic test_typematic();
        int p0;
        do_reset();
        p0 = pulses_seen;
        repeat (4) push(8'h1C);
        push(8'hF0); push(8'h1C);
        drain("typematic");
        checks++;
        if (bus.press_count !== 8'd1 || pulses_seen - p0 != 1 || bus.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL typematic got n=%0d pulses=%0d v=%0b expected 1 1 0",
                     bus.press_count, pulses_seen - p0, bus.key_valid);
        end
    endtask

    task automatic test_extended();
        do_reset();
        push(8'hE0); push(8'h75);
        drain("ext_make");
        checks++;
        if (bus.key_valid !== 1'b1 || bus.key_code !== 8'h75 || bus.key_ext !== 1'b1 || bus.press_count !== 8'd1) begin
            errors++;
            $display("FAIL ext_held got v=%0b c=%02h e=%0b n=%0d expected 1 75 1 1",
                     bus.key_valid, bus.key_code, bus.key_ext, bus.press_count);
        end
        push(8'hF0); push(8'h75);
        drain("ext_plain_break");
        checks++;
        if (bus.key_valid !== 1'b1 || bus.key_code !== 8'h75 || bus.key_ext !== 1'b1) begin
            errors++;
            $display("FAIL ext_mismatch_release got v=%0b c=%02h e=%0b expected 1 75 1",
                     bus.key_valid, bus.key_code, bus.key_ext);
        end
        push(8'hE0); push(8'hF0); push(8'h75);
        drain("ext_break");
        checks++;
        if (bus.key_valid !== 1'b0 || bus.key_code !== 8'h00 || bus.key_ext !== 1'b0 || bus.press_count !== 8'd1) begin
            errors++;
            $display("FAIL ext_released got v=%0b c=%02h e=%0b n=%0d expected 0 00 0 1",
                     bus.key_valid, bus.key_code, bus.key_ext, bus.press_count);
        end
    endtask

    task automatic test_wrap();
        int p0;
        do_reset();
        p0 = pulses_seen;
        for (int i = 0; i < 256; i++) push((i % 2 == 1) ? 8'h32 : 8'h1C);
        drain("wrap");
        checks++;
        if (bus.press_count !== 8'h00 || pulses_seen - p0 != 256 || bus.key_valid !== 1'b1 || bus.key_code !== 8'h32) begin
            errors++;
            $display("FAIL wrap got n=%02h pulses=%0d v=%0b c=%02h expected 00 256 1 32",
                     bus.press_count, pulses_seen - p0, bus.key_valid, bus.key_code);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int n = 0;
        do_reset();
        push(8'h1C);
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.kbd_nextdata_n !== 1'b0 && n < 50);
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL midfetch_pop_timeout nextdata_n=%0b expected 0", bus.kbd_nextdata_n);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus.kbd_nextdata_n !== 1'b1 || bus.key_valid !== 1'b0 || bus.press_count !== 8'h00) begin
            errors++;
            $display("FAIL midfetch_reset got nd=%0b v=%0b n=%0d expected 1 0 0",
                     bus.kbd_nextdata_n, bus.key_valid, bus.press_count);
        end
        drain("midfetch");
        checks++;
        if (bus.key_valid !== 1'b0 || bus.press_count !== 8'h00) begin
            errors++;
            $display("FAIL midfetch_dropped got v=%0b n=%0d expected 0 0", bus.key_valid, bus.press_count);
        end
    endtask

    task automatic test_overflow();
        @(posedge clk); #1; bus.kbd_overflow = 1'b1;
        @(posedge clk); #1; bus.kbd_overflow = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got %0b expected 1", bus.ovf_sticky);
        end
        @(posedge clk); #1; bus.kbd_overflow = 1'b1; bus.clr_ovf = 1'b1;
        @(posedge clk); #1; bus.kbd_overflow = 1'b0; bus.clr_ovf = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins got %0b expected 1", bus.ovf_sticky);
        end
        @(posedge clk); #1; bus.clr_ovf = 1'b1;
        @(posedge clk); #1; bus.clr_ovf = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %0b expected 0", bus.ovf_sticky);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [8];
        logic [7:0] b;
        int c0, p0;
        pool[0] = 8'h1C; pool[1] = 8'h32; pool[2] = 8'h75; pool[3] = 8'hE0;
        pool[4] = 8'hF0; pool[5] = 8'h00; pool[6] = 8'hFF; pool[7] = 8'h1C;
        do_reset();
        c0 = int'(bus.press_count); p0 = pulses_seen;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            bus.kbd_overflow = ($urandom_range(0, 15) == 0);
            bus.clr_ovf      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
                push(b);
            end
        end
        @(posedge clk); #1;
        bus.kbd_overflow = 1'b0; bus.clr_ovf = 1'b0;
        drain("random");
        checks++;
        if (int'(bus.press_count) != (c0 + pulses_seen - p0) % 256) begin
            errors++;
            $display("FAIL random_count got %0d expected %0d", bus.press_count, (c0 + pulses_seen - p0) % 256);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.kbd_overflow = 1'b0;
        bus.clr_ovf = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        test_reset();
        test_single_press();
        test_typematic();
        test_extended();
        test_wrap();
        test_reset_mid_fetch();
        test_overflow();
        test_random();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
